// File: rtl/sdram_wb_pkg.sv
// Shared types and helpers for the Wishbone-to-SDRAM round-robin arbiter.
package sdram_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_WR,
    WAIT_RD,
    ACK
  } state_t;

  // Width of the watchdog counter needed to hold values up to timeout.
  // A disabled watchdog (timeout = 0) still gets a one-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  // SDRAM DQM is active-high "mask this byte", the inverse of a Wishbone select.
  function automatic logic sel_to_mask(input logic sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/sdram_wb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0] rotated;

  // Rotate so bit 0 is the port at ptr, then take the lowest set bit.
  always_comb begin
    rotated     = N'({req, req} >> ptr);
    grant_valid = |rotated;
    grant_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        grant_idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Multi-port Wishbone classic slave arbitrated round-robin onto one SDRAM
// controller host port, with byte masking, abort handling and a watchdog.
module sdram_wb_arbiter
  import sdram_wb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 1024,
  localparam int SEL_W    = DATA_W / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_PORTS-1:0]        wb_cyc_i,
  input  logic [NUM_PORTS-1:0]        wb_stb_i,
  input  logic [NUM_PORTS-1:0]        wb_we_i,
  input  logic [NUM_PORTS*SEL_W-1:0]  wb_sel_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] wb_adr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0]           wb_dat_o,
  output logic [NUM_PORTS-1:0]        wb_ack_o,
  output logic [NUM_PORTS-1:0]        wb_err_o,
  output logic [ADDR_W-1:0]           host_addr,
  output logic [DATA_W-1:0]           host_wr_data,
  output logic [SEL_W-1:0]            host_wr_mask,
  output logic                        host_wr_enable,
  output logic                        host_rd_enable,
  input  logic [DATA_W-1:0]           host_rd_data,
  input  logic                        host_rd_ready,
  input  logic                        host_busy
);

  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = cnt_width(TIMEOUT);
  // The error is registered on the edge where the counter reaches TIMEOUT-1,
  // so expiry is detected one count earlier.
  localparam int EXPIRE = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

  state_t               state, state_next;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [NUM_PORTS-1:0] arb_oh;
  logic                 cur_we;
  logic                 saw_busy;
  logic                 aborted;
  logic [CNT_W-1:0]     watchdog;
  logic                 cyc_granted;
  logic                 do_grant;
  logic                 done;
  logic                 expired;
  logic [SEL_W-1:0]     sel_pick;
  logic [SEL_W-1:0]     mask_pick;

  assign req         = wb_cyc_i & wb_stb_i;
  assign grant_oh    = NUM_PORTS'(1) << grant;
  assign arb_oh      = NUM_PORTS'(1) << arb_idx;
  assign cyc_granted = |(wb_cyc_i & grant_oh);
  assign sel_pick    = wb_sel_i[arb_idx*SEL_W +: SEL_W];

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_rr (
    .req        (req),
    .ptr        (rr_ptr),
    .grant_valid(arb_valid),
    .grant_idx  (arb_idx)
  );

  // Convert the candidate port's byte selects into DQM-polarity mask bits.
  always_comb begin
    mask_pick = '1;
    for (int b = 0; b < SEL_W; b++) begin
      mask_pick[b] = sel_to_mask(sel_pick[b]);
    end
  end

  // Next-state logic; completion is checked before the watchdog so it wins ties.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    done       = 1'b0;
    expired    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid && !host_busy) begin
          do_grant   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = cur_we ? WAIT_WR : WAIT_RD;
      WAIT_WR: done = saw_busy && !host_busy;
      WAIT_RD: done = host_rd_ready;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state == WAIT_WR || state == WAIT_RD) begin
      expired = (TIMEOUT != 0) && (watchdog == CNT_W'(EXPIRE)) && !done;
      if (done) begin
        state_next = ACK;
      end else if (expired) begin
        state_next = IDLE;
      end
    end
  end

  // State, latched request, watchdog and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant          <= '0;
      cur_we         <= 1'b0;
      saw_busy       <= 1'b0;
      aborted        <= 1'b0;
      watchdog       <= '0;
      wb_ack_o       <= '0;
      wb_err_o       <= '0;
      wb_dat_o       <= '0;
      host_addr      <= '0;
      host_wr_data   <= '0;
      host_wr_mask   <= '1;
      host_wr_enable <= 1'b0;
      host_rd_enable <= 1'b0;
    end else begin
      state          <= state_next;
      wb_ack_o       <= '0;
      wb_err_o       <= '0;
      host_wr_enable <= 1'b0;
      host_rd_enable <= 1'b0;

      if (do_grant) begin
        grant          <= arb_idx;
        rr_ptr         <= (arb_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
        cur_we         <= |(wb_we_i & arb_oh);
        aborted        <= 1'b0;
        host_addr      <= wb_adr_i[arb_idx*ADDR_W +: ADDR_W];
        host_wr_data   <= wb_dat_i[arb_idx*DATA_W +: DATA_W];
        host_wr_mask   <= mask_pick;
        host_wr_enable <= |(wb_we_i & arb_oh);
        host_rd_enable <= ~|(wb_we_i & arb_oh);
      end

      if (state == ISSUE) begin
        watchdog <= '0;
        saw_busy <= 1'b0;
      end

      if (state == WAIT_WR || state == WAIT_RD) begin
        watchdog <= watchdog + 1'b1;
      end

      if (state == WAIT_WR && host_busy) begin
        saw_busy <= 1'b1;
      end

      if ((state == ISSUE || state == WAIT_WR || state == WAIT_RD) && !cyc_granted) begin
        aborted <= 1'b1;
      end

      if (state == WAIT_RD && host_rd_ready) begin
        wb_dat_o <= host_rd_data;
      end

      if (done && !aborted && cyc_granted) begin
        wb_ack_o <= grant_oh;
      end

      if (expired && !aborted && cyc_granted) begin
        wb_err_o <= grant_oh;
      end
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed self-checking bench for sdram_wb_arbiter (2 ports, 16-bit, TIMEOUT=16).
module tb_sdram_wb_arbiter;

  localparam int NP = 2;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     wb_cyc_i;
  logic [NP-1:0]     wb_stb_i;
  logic [NP-1:0]     wb_we_i;
  logic [NP*SW-1:0]  wb_sel_i;
  logic [NP*AW-1:0]  wb_adr_i;
  logic [NP*DW-1:0]  wb_dat_i;
  logic [DW-1:0]     wb_dat_o;
  logic [NP-1:0]     wb_ack_o;
  logic [NP-1:0]     wb_err_o;
  logic [AW-1:0]     host_addr;
  logic [DW-1:0]     host_wr_data;
  logic [SW-1:0]     host_wr_mask;
  logic              host_wr_enable;
  logic              host_rd_enable;
  logic [DW-1:0]     host_rd_data;
  logic              host_rd_ready;
  logic              host_busy;

  int errors = 0;
  int checks = 0;

  sdram_wb_arbiter #(
    .NUM_PORTS(NP),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .TIMEOUT  (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_sel_i      (wb_sel_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
    .wb_err_o      (wb_err_o),
    .host_addr     (host_addr),
    .host_wr_data  (host_wr_data),
    .host_wr_mask  (host_wr_mask),
    .host_wr_enable(host_wr_enable),
    .host_rd_enable(host_rd_enable),
    .host_rd_data  (host_rd_data),
    .host_rd_ready (host_rd_ready),
    .host_busy     (host_busy)
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int p, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [SW-1:0] s);
    wb_cyc_i[p]            = 1'b1;
    wb_stb_i[p]            = 1'b1;
    wb_we_i[p]             = w;
    wb_adr_i[p*AW +: AW]   = a;
    wb_dat_i[p*DW +: DW]   = d;
    wb_sel_i[p*SW +: SW]   = s;
  endtask

  task automatic releasePort(input int p);
    wb_cyc_i[p] = 1'b0;
    wb_stb_i[p] = 1'b0;
  endtask

  task automatic waitEnable(input string tag, input int budget);
    int n;
    n = 0;
    while (!(host_wr_enable || host_rd_enable) && n < budget) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(host_wr_enable | host_rd_enable), 32'h1);
  endtask

  task automatic waitAck(input string tag, input int budget, input logic [NP-1:0] exp);
    int n;
    n = 0;
    while (wb_ack_o == '0 && wb_err_o == '0 && n < budget) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(wb_ack_o), 32'(exp));
  endtask

  // Called in the enable cycle: controller raises busy for two cycles.
  task automatic busyPulse();
    step();
    host_busy = 1'b1;
    step();
    step();
    host_busy = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] fair_adr [4];
    logic [NP-1:0] fair_ack [4];

    rst_i         = 1'b1;
    wb_cyc_i      = '0;
    wb_stb_i      = '0;
    wb_we_i       = '0;
    wb_sel_i      = '0;
    wb_adr_i      = '0;
    wb_dat_i      = '0;
    host_rd_data  = '0;
    host_rd_ready = 1'b0;
    host_busy     = 1'b0;

    // Reset values
    step();
    step();
    checkOutput("rst_ack", 32'(wb_ack_o), 32'h0);
    checkOutput("rst_err", 32'(wb_err_o), 32'h0);
    checkOutput("rst_wren", 32'(host_wr_enable), 32'h0);
    checkOutput("rst_rden", 32'(host_rd_enable), 32'h0);
    checkOutput("rst_addr", host_addr, 32'h0);
    checkOutput("rst_wdata", 32'(host_wr_data), 32'h0);
    checkOutput("rst_dato", 32'(wb_dat_o), 32'h0);
    checkOutput("rst_mask", 32'(host_wr_mask), 32'h3);
    rst_i = 1'b0;
    step();

    // Single write on port 0
    $display("[TB] single write");
    applyStimulus(0, 1'b1, 32'h100, 16'hBEEF, 2'b01);
    step();
    checkOutput("wr_en", 32'(host_wr_enable), 32'h1);
    checkOutput("wr_rden", 32'(host_rd_enable), 32'h0);
    checkOutput("wr_addr", host_addr, 32'h100);
    checkOutput("wr_data", 32'(host_wr_data), 32'hBEEF);
    checkOutput("wr_mask", 32'(host_wr_mask), 32'h2);
    step();
    checkOutput("wr_en_pulse", 32'(host_wr_enable), 32'h0);
    host_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("wr_noack_busy", 32'(wb_ack_o), 32'h0);
      step();
    end
    host_busy = 1'b0;
    checkOutput("wr_noack_fall", 32'(wb_ack_o), 32'h0);
    step();
    checkOutput("wr_ack", 32'(wb_ack_o), 32'h1);
    releasePort(0);
    step();
    checkOutput("wr_ack_once", 32'(wb_ack_o), 32'h0);

    // Read on port 1, data arrives five cycles after the enable
    $display("[TB] read");
    applyStimulus(1, 1'b0, 32'h200, 16'h0, 2'b11);
    step();
    checkOutput("rd_en", 32'(host_rd_enable), 32'h1);
    checkOutput("rd_wren", 32'(host_wr_enable), 32'h0);
    checkOutput("rd_addr", host_addr, 32'h200);
    for (int i = 0; i < 5; i++) step();
    checkOutput("rd_noack", 32'(wb_ack_o), 32'h0);
    host_rd_ready = 1'b1;
    host_rd_data  = 16'h1234;
    step();
    host_rd_ready = 1'b0;
    host_rd_data  = 16'h0;
    checkOutput("rd_ack", 32'(wb_ack_o), 32'h2);
    checkOutput("rd_data", 32'(wb_dat_o), 32'h1234);
    releasePort(1);
    step();
    checkOutput("rd_ack_once", 32'(wb_ack_o), 32'h0);

    // Fairness: both ports write continuously; pointer now favours port 0
    $display("[TB] fairness");
    fair_adr = '{32'h10, 32'h20, 32'h10, 32'h20};
    fair_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
    applyStimulus(0, 1'b1, 32'h10, 16'hAAAA, 2'b11);
    applyStimulus(1, 1'b1, 32'h20, 16'h5555, 2'b11);
    for (int t = 0; t < 4; t++) begin
      waitEnable("fair_enable", 10);
      checkOutput("fair_addr", host_addr, fair_adr[t]);
      busyPulse();
      waitAck("fair_ack", 8, fair_ack[t]);
    end
    releasePort(0);
    releasePort(1);
    step();

    // Watchdog: read with no rd_ready, error exactly 16 cycles after enable
    $display("[TB] timeout");
    applyStimulus(0, 1'b0, 32'h300, 16'h0, 2'b11);
    step();
    checkOutput("to_rden", 32'(host_rd_enable), 32'h1);
    for (int k = 1; k <= 15; k++) begin
      step();
      checkOutput("to_noerr", 32'(wb_err_o), 32'h0);
    end
    step();
    checkOutput("to_err", 32'(wb_err_o), 32'h1);
    checkOutput("to_noack", 32'(wb_ack_o), 32'h0);
    releasePort(0);
    step();
    checkOutput("to_err_once", 32'(wb_err_o), 32'h0);
    applyStimulus(1, 1'b1, 32'h400, 16'h4444, 2'b10);
    step();
    checkOutput("to_next_en", 32'(host_wr_enable), 32'h1);
    checkOutput("to_next_addr", host_addr, 32'h400);
    checkOutput("to_next_mask", 32'(host_wr_mask), 32'h1);
    busyPulse();
    waitAck("to_next_ack", 8, 2'b10);
    releasePort(1);
    step();

    // Abort: port 0 drops cyc mid-read, port 1 waits its turn
    $display("[TB] abort");
    applyStimulus(0, 1'b0, 32'h500, 16'h0, 2'b11);
    applyStimulus(1, 1'b1, 32'h600, 16'h6666, 2'b11);
    step();
    checkOutput("ab_rden", 32'(host_rd_enable), 32'h1);
    checkOutput("ab_addr", host_addr, 32'h500);
    step();
    releasePort(0);
    step();
    step();
    host_rd_ready = 1'b1;
    host_rd_data  = 16'hAAAA;
    step();
    host_rd_ready = 1'b0;
    host_rd_data  = 16'h0;
    checkOutput("ab_noack", 32'(wb_ack_o), 32'h0);
    checkOutput("ab_data", 32'(wb_dat_o), 32'hAAAA);
    step();
    checkOutput("ab_noack2", 32'(wb_ack_o), 32'h0);
    waitEnable("ab_next_en", 6);
    checkOutput("ab_next_addr", host_addr, 32'h600);
    checkOutput("ab_next_wr", 32'(host_wr_enable), 32'h1);
    busyPulse();
    waitAck("ab_next_ack", 8, 2'b10);
    releasePort(1);
    step();

    // Reset while waiting for the write to finish
    $display("[TB] reset mid-write");
    applyStimulus(0, 1'b1, 32'h700, 16'h5555, 2'b11);
    step();
    checkOutput("mr_mask", 32'(host_wr_mask), 32'h0);
    step();
    host_busy = 1'b1;
    step();
    rst_i     = 1'b1;
    host_busy = 1'b0;
    releasePort(0);
    step();
    checkOutput("mr_wren", 32'(host_wr_enable), 32'h0);
    checkOutput("mr_addr", host_addr, 32'h0);
    checkOutput("mr_wdata", 32'(host_wr_data), 32'h0);
    checkOutput("mr_mask_rst", 32'(host_wr_mask), 32'h3);
    checkOutput("mr_dato", 32'(wb_dat_o), 32'h0);
    checkOutput("mr_ack", 32'(wb_ack_o), 32'h0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("mr_quiet", 32'({wb_ack_o, wb_err_o, host_wr_enable, host_rd_enable}), 32'h0);
    end
    applyStimulus(1, 1'b0, 32'h800, 16'h0, 2'b11);
    step();
    checkOutput("mr_next_rden", 32'(host_rd_enable), 32'h1);
    checkOutput("mr_next_addr", host_addr, 32'h800);
    step();
    step();
    host_rd_ready = 1'b1;
    host_rd_data  = 16'h0F0F;
    step();
    host_rd_ready = 1'b0;
    host_rd_data  = 16'h0;
    checkOutput("mr_next_ack", 32'(wb_ack_o), 32'h2);
    checkOutput("mr_next_data", 32'(wb_dat_o), 32'h0F0F);
    releasePort(1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
